pdm_mic_capture: RTL and testbench



---
 rtl/pdm_mic_capture.sv | 173 +++++++++++++++++
 tb/tb_pdm_mic_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: mic clock generation, ones-count decimation to PCM
// and a first-word-fall-through sample FIFO, with optional PDM-to-amp loopback.
module pdm_mic_capture #(
  parameter int MCLK_HALF  = 25,
  parameter int DECIM      = 64,
  parameter int PCM_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit CHANNEL    = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          loop_en,
  input  logic                          micData,
  output logic                          mclk,
  output logic                          micLRSel,
  output logic                          ampPWM,
  output logic                          ampSD,
  input  logic                          rd,
  output logic [PCM_W-1:0]              dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_ovf,
  output logic                          overflow
);

  localparam int DIV_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int BC_W  = $clog2(DECIM);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {IDLE, ACC} dec_state_e;

  // Mic clock divider
  logic [DIV_W-1:0] div_q;
  logic             mclk_q;
  logic             div_tc;
  logic             stb;

  assign div_tc = (div_q == DIV_W'(MCLK_HALF - 1));
  assign stb    = en && div_tc && mclk_q;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div_q  <= '0;
      mclk_q <= 1'b0;
    end else if (div_tc) begin
      div_q  <= '0;
      mclk_q <= ~mclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  // Boxcar decimator: the final bit is folded in on its strobe, so acc restarts without a gap
  dec_state_e       state_q;
  logic             pdm_bit_q;
  logic [BC_W-1:0]  bitcnt_q;
  logic [PCM_W-1:0] acc_q;
  logic [PCM_W-1:0] sample_q;
  logic             wr_q;
  logic [PCM_W-1:0] acc_sum;
  logic             last_bit;

  assign acc_sum  = acc_q + {{(PCM_W-1){1'b0}}, micData};
  assign last_bit = (bitcnt_q == BC_W'(DECIM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pdm_bit_q <= 1'b0;
      bitcnt_q  <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      wr_q      <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (stb) pdm_bit_q <= micData;
      if (!en) begin
        state_q  <= IDLE;
        bitcnt_q <= '0;
        acc_q    <= '0;
      end else begin
        state_q <= ACC;
        if (state_q == ACC && stb) begin
          if (last_bit) begin
            sample_q <= acc_sum;
            wr_q     <= 1'b1;
            acc_q    <= '0;
            bitcnt_q <= '0;
          end else begin
            acc_q    <= acc_sum;
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Amplifier loopback
  logic amp_sd_q;
  logic amp_pwm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      amp_sd_q  <= 1'b0;
      amp_pwm_q <= 1'b0;
    end else begin
      amp_sd_q  <= loop_en;
      amp_pwm_q <= loop_en & (stb ? micData : pdm_bit_q);
    end
  end

  // Sample FIFO; dout is a register tracking the head so it stays defined after reset
  logic [PCM_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, ovf_q, ovf_d;
  logic [PCM_W-1:0] dout_q, dout_d;
  logic             do_rd, do_wr, drop;

  always_comb begin
    do_rd   = rd && !empty_q;
    do_wr   = wr_q && (!full_q || do_rd);
    drop    = wr_q && full_q && !do_rd;
    rd_nxt  = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
    ovf_d   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    dout_d  = dout_q;
    if (do_rd) begin
      if (count_q > CW'(1))  dout_d = mem_q[rd_nxt];
      else if (do_wr)        dout_d = sample_q;
    end else if (do_wr && empty_q) begin
      dout_d = sample_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= sample_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (do_rd) rd_ptr_q <= rd_nxt;
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  assign mclk     = mclk_q;
  assign micLRSel = CHANNEL;
  assign ampPWM   = amp_pwm_q;
  assign ampSD    = amp_sd_q;
  assign dout     = dout_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Testbench for pdm_mic_capture: table-driven PDM sample vectors with a scoreboard
// queue of expected PCM samples, plus directed FIFO, enable, loopback and reset sequences.
`timescale 1ns/1ps
module tb_pdm_mic_capture;

  localparam int MCLK_HALF  = 2;
  localparam int DECIM      = 4;
  localparam int PCM_W      = 4;
  localparam int FIFO_DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        reset, en, loop_en, micData, rd, clr_ovf;
  logic                        mclk, micLRSel, ampPWM, ampSD, empty, full, overflow;
  logic [PCM_W-1:0]            dout;
  logic [$clog2(FIFO_DEPTH):0] count;

  pdm_mic_capture #(
    .MCLK_HALF(MCLK_HALF), .DECIM(DECIM), .PCM_W(PCM_W),
    .FIFO_DEPTH(FIFO_DEPTH), .CHANNEL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .loop_en(loop_en), .micData(micData),
    .mclk(mclk), .micLRSel(micLRSel), .ampPWM(ampPWM), .ampSD(ampSD),
    .rd(rd), .dout(dout), .empty(empty), .full(full), .count(count),
    .clr_ovf(clr_ovf), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bits;
    int         exp;
  } vec_t;

  vec_t tv [6];
  int   checks = 0;
  int   errors = 0;
  int   exp_q [$];
  int   last_val = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input string name);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, dout=%0d", name, dout);
    end else begin
      e = exp_q.pop_front();
      chk(name, int'(dout), e);
      last_val = e;
    end
  endtask

  // Drives one DECIM-bit sample, each bit held for a full mic clock period.
  task automatic send_sample(input logic [3:0] bits, input int exp, input bit pop_first,
                             input bit chk_mclk, input bit chk_amp, input bit push);
    for (int j = 0; j < 16; j++) begin
      micData = bits[j>>2];
      step();
      rd = 1'b0;
      if (chk_mclk && j < 8) begin
        chk("mclk_wave", int'(mclk), ((j + 1) >> 1) & 1);
        chk("micLRSel", int'(micLRSel), 0);
      end
      if (chk_amp && (j % 4) == 3) chk("ampPWM_follow", int'(ampPWM), int'(bits[j>>2]));
      if (j == 0 && pop_first) begin
        chk("empty_before_pop", int'(empty), 0);
        pop_chk("dout_stream");
        rd = 1'b1;
      end
    end
    if (push) exp_q.push_back(exp);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_empty", int'(empty), 0);
      pop_chk("drain_dout");
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    chk("drained_empty", int'(empty), 1);
    chk("drained_count", int'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{4'b1111, 4};
    tv[1] = '{4'b1111, 4};
    tv[2] = '{4'b1010, 2};
    tv[3] = '{4'b0101, 2};
    tv[4] = '{4'b0000, 0};
    tv[5] = '{4'b1011, 3};

    reset = 1'b1; en = 1'b0; loop_en = 1'b0; micData = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    step(); step(); step();
    chk("rst_mclk", int'(mclk), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ampPWM", int'(ampPWM), 0);
    chk("rst_ampSD", int'(ampSD), 0);
    chk("rst_micLRSel", int'(micLRSel), 0);

    // Streaming samples with the consumer keeping up
    reset = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++)
      send_sample(tv[i].bits, tv[i].exp, i > 0, i == 0, 1'b0, 1'b1);
    en = 1'b0;
    step();
    drain(1);

    // Fill to full, then drop one sample
    en = 1'b1;
    send_sample(4'b0001, 1, 0, 0, 0, 1);
    send_sample(4'b0011, 2, 0, 0, 0, 1);
    send_sample(4'b0111, 3, 0, 0, 0, 1);
    send_sample(4'b1111, 4, 0, 0, 0, 1);
    en = 1'b0;
    step();
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 4);
    chk("fill_overflow", int'(overflow), 0);
    en = 1'b1;
    send_sample(4'b1001, 2, 0, 0, 0, 0);
    en = 1'b0;
    step();
    chk("drop_overflow", int'(overflow), 1);
    chk("drop_count", int'(count), 4);
    chk("drop_full", int'(full), 1);
    chk("drop_head", int'(dout), exp_q[0]);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_overflow", int'(overflow), 0);

    // Write and read in the same cycle while full
    en = 1'b1;
    send_sample(4'b1110, 3, 0, 0, 0, 0);
    en = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(3);
    chk("wr_rd_full_count", int'(count), 4);
    chk("wr_rd_full_overflow", int'(overflow), 0);
    chk("wr_rd_full_head", int'(dout), exp_q[0]);
    drain(4);

    // Read while empty
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("rd_empty_count", int'(count), 0);
    chk("rd_empty_flag", int'(empty), 1);
    chk("rd_empty_dout", int'(dout), last_val);

    // Partial sample discarded by en=0
    en = 1'b1; micData = 1'b1;
    for (int j = 0; j < 8; j++) step();
    en = 1'b0;
    step(); step(); step();
    en = 1'b1;
    send_sample(4'b0001, 1, 0, 0, 0, 1);
    en = 1'b0;
    step();
    chk("restart_count", int'(count), 1);
    drain(1);

    // Loopback to amplifier
    loop_en = 1'b1;
    step();
    chk("loop_ampSD", int'(ampSD), 1);
    en = 1'b1;
    send_sample(4'b0110, 2, 0, 0, 1, 1);
    en = 1'b0; loop_en = 1'b0;
    step();
    chk("loop_off_ampSD", int'(ampSD), 0);
    chk("loop_off_ampPWM", int'(ampPWM), 0);

    // Reset in the middle of a sample with two entries stored
    en = 1'b1;
    send_sample(4'b1111, 4, 0, 0, 0, 1);
    en = 1'b0;
    step();
    chk("pre_reset_count", int'(count), 2);
    en = 1'b1; micData = 1'b1;
    for (int j = 0; j < 8; j++) step();
    reset = 1'b1;
    step();
    exp_q.delete();
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_mclk", int'(mclk), 0);
    reset = 1'b0;
    send_sample(4'b0111, 3, 0, 0, 0, 1);
    en = 1'b0;
    step();
    chk("post_reset_count", int'(count), 1);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
